// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-phase arbiter requester.
package arb_pkg;

  // Requester FSM: waiting for work, requesting beats, one-cycle fairness gap.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_DEPTH      = 4;
  localparam int ARB_LEN_W      = 4;
  localparam int ARB_WAIT_LIMIT = 15;

endpackage

// File: rtl/arb_job_fifo.sv
// Pending-job FIFO: stores job lengths, exposes the head combinationally.
module arb_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage entries carry no reset; validity is tracked by the pointers alone.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_reg == AW'(gi))) mem[gi] <= din;
    end
  end

  // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/arb2_requester.sv
// Requester front-end: queues jobs, requests one grant per beat, leaves a
// one-cycle gap between jobs and flags starvation of the pending request.
module arb2_requester
  import arb_pkg::*;
#(
  parameter int DEPTH      = ARB_DEPTH,
  parameter int LEN_W      = ARB_LEN_W,
  parameter int WAIT_LIMIT = ARB_WAIT_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  input  logic [LEN_W-1:0]       job_len,
  output logic                   job_ready,
  output logic                   req,
  input  logic                   gnt,
  output logic                   done,
  output logic                   busy,
  output logic                   starve,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  arb_state_t        state_reg, state_next;
  logic [LEN_W-1:0]  beat_reg, beat_next;
  logic [WW-1:0]     wait_reg, wait_next;
  logic              done_reg, done_next;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [LEN_W-1:0]  head_len, head_beats;
  logic [CW-1:0]     fifo_count;

  arb_job_fifo #(.DEPTH(DEPTH), .W(LEN_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (job_len),
    .head  (head_len),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Readiness is judged on pre-pop occupancy, so a full FIFO refuses even when draining.
  assign job_ready  = !fifo_full;
  assign fifo_push  = job_valid && job_ready;
  // A zero-length job still needs one granted beat.
  assign head_beats = (head_len == '0) ? LEN_W'(1) : head_len;

  assign req    = (state_reg == ST_REQ);
  assign done   = done_reg;
  assign busy   = (state_reg != ST_IDLE) || !fifo_empty;
  assign starve = (wait_reg == WW'(WAIT_LIMIT));
  assign count  = fifo_count;

  // Next-state, beat accounting, pop and done generation.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    done_next  = 1'b0;
    fifo_pop   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_REQ;
          beat_next  = head_beats;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          if (beat_reg == LEN_W'(1)) begin
            fifo_pop   = 1'b1;
            done_next  = 1'b1;
            beat_next  = '0;
            state_next = ST_RELEASE;
          end else begin
            beat_next = beat_reg - LEN_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        if (!fifo_empty) begin
          state_next = ST_REQ;
          beat_next  = head_beats;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Ungranted-request counter; any grant clears it, which also covers leaving REQ.
  always_comb begin
    wait_next = wait_reg;
    if (gnt) begin
      wait_next = '0;
    end else if (state_reg != ST_REQ) begin
      wait_next = '0;
    end else if (wait_reg != WW'(WAIT_LIMIT)) begin
      wait_next = wait_reg + WW'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
      wait_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      wait_reg  <= wait_next;
      done_reg  <= done_next;
    end
  end

endmodule

// File: tb/tb_arb2_requester.sv
// Self-checking bench for arb2_requester: directed scenarios plus random
// traffic, all checked against a queue-based behavioural model.
module tb_arb2_requester;

  localparam int DEPTH = 4;
  localparam int LIMIT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       job_valid;
  logic [3:0] job_len;
  logic       job_ready;
  logic       req;
  logic       gnt;
  logic       done;
  logic       busy;
  logic       starve;
  logic [2:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: queue of pending lengths plus the job being served.
  int mq[$];
  bit m_serving, m_gap, m_done;
  int m_beats_left, m_wait;

  arb2_requester dut (
    .clk       (clk),
    .rst       (rst),
    .job_valid (job_valid),
    .job_len   (job_len),
    .job_ready (job_ready),
    .req       (req),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .starve    (starve),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    m_serving = 0; m_gap = 0; m_done = 0;
    m_beats_left = 0; m_wait = 0;
  endfunction

  // One rising edge of the model with the inputs that were present before it.
  function automatic void model_edge(bit v, int len, bit g);
    int  old_size   = mq.size();
    bit  was_req    = m_serving;
    bit  accept     = v && (old_size < DEPTH);
    m_done = 0;
    if (m_serving) begin
      if (g) begin
        if (m_beats_left == 1) begin
          mq.delete(0);
          m_serving = 0;
          m_gap     = 1;
          m_done    = 1;
        end else begin
          m_beats_left = m_beats_left - 1;
        end
      end
    end else begin
      m_gap = 0;
      if (old_size != 0) begin
        m_serving    = 1;
        m_beats_left = (mq[0] == 0) ? 1 : mq[0];
      end
    end
    if (g) m_wait = 0;
    else if (was_req && m_wait < LIMIT) m_wait = m_wait + 1;
    if (accept) mq.push_back(len);
  endfunction

  function automatic logic [7:0] model_vec();
    logic [2:0] c;
    c = 3'(mq.size());
    return {m_serving, m_done, (m_serving || m_gap || mq.size() != 0),
            (m_wait == LIMIT), (mq.size() != DEPTH), c};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {req, done, busy, starve, job_ready, count};
  endfunction

  // Drive one cycle of inputs, let an edge pass, advance the model, settle.
  task automatic step(input bit v, input int len, input bit g);
    job_valid = v;
    job_len   = 4'(len);
    gnt       = g;
    @(posedge clk);
    model_edge(v, len, g);
    #1;
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    job_valid = 0; job_len = 0; gnt = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; job_valid = 0; job_len = 0; gnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec() !== 8'b0000_1000) $display("FAIL reset_hold: got %b want %b", dut_vec(), 8'b0000_1000);
    else n_pass++;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (dut_vec() !== model_vec()) $display("FAIL reset_release: got %b want %b", dut_vec(), model_vec());
    else n_pass++;
    $display("reset: req=%0d busy=%0d ready=%0d count=%0d", req, busy, job_ready, count);
  endtask

  task automatic test_single_job();
    apply_reset();
    step(1, 3, 1);                       // edge 0: push
    n_checks++;
    if (req !== 1'b0 || count !== 3'd1) $display("FAIL single_push: req=%0d count=%0d want req=0 count=1", req, count);
    else n_pass++;
    step(0, 0, 1);                       // edge 1: enter REQ
    n_checks++;
    if (req !== 1'b1) $display("FAIL single_req_rise: req=%0d want 1", req);
    else n_pass++;
    for (int e = 2; e <= 4; e++) begin
      step(0, 0, 1);
      n_checks++;
      if (done !== (e == 4) || req !== (e != 4)) $display("FAIL single_beat%0d: done=%0d req=%0d", e, done, req);
      else n_pass++;
      $display("single: edge %0d req=%0d done=%0d", e, req, done);
    end
    step(0, 0, 1);                       // edge 5: RELEASE -> IDLE
    n_checks++;
    if (busy !== 1'b0 || req !== 1'b0 || done !== 1'b0) $display("FAIL single_idle: busy=%0d req=%0d done=%0d want 0 0 0", busy, req, done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lens[3] = '{1, 2, 1};
    int dones = 0;
    int gaps  = 0;
    bit prev_req = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) step(1, lens[i], 1);
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL b2b_cycle%0d: got %b want %b", c, dut_vec(), model_vec());
      else n_pass++;
      if (done) dones++;
      if (prev_req && !req && mq.size() != 0) gaps++;
      prev_req = req;
      step(0, 0, 1);
    end
    n_checks++;
    if (dones !== 3) $display("FAIL b2b_done_count: got %0d want 3", dones);
    else n_pass++;
    $display("back_to_back: done pulses=%0d release gaps=%0d", dones, gaps);
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, i + 1, 0);
    n_checks++;
    if (count !== 3'd4 || job_ready !== 1'b0) $display("FAIL full_level: count=%0d ready=%0d want 4 0", count, job_ready);
    else n_pass++;
    step(1, 9, 0);                       // refused
    n_checks++;
    if (count !== 3'd4) $display("FAIL full_refuse: count=%0d want 4", count);
    else n_pass++;
    step(1, 5, 1);                       // pop at full: push still refused
    n_checks++;
    if (dut_vec() !== model_vec() || count !== 3'd3) $display("FAIL full_pop: got %b want %b", dut_vec(), model_vec());
    else n_pass++;
    step(0, 0, 0);                       // RELEASE -> REQ with head len 2
    step(0, 0, 1);                       // first beat of len-2 job
    step(1, 6, 1);                       // last beat pops while a push lands
    n_checks++;
    if (count !== 3'd3 || dut_vec() !== model_vec()) $display("FAIL full_push_pop: count=%0d got %b want %b", count, dut_vec(), model_vec());
    else n_pass++;
    for (int c = 0; c < 30; c++) begin
      step(0, 0, 1);
      n_checks++;
      if (dut_vec() !== model_vec()) $display("FAIL full_drain%0d: got %b want %b", c, dut_vec(), model_vec());
      else n_pass++;
    end
    $display("full: drained count=%0d busy=%0d", count, busy);
  endtask

  task automatic test_starve();
    apply_reset();
    step(1, 1, 0);
    step(0, 0, 0);                       // req rises
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0);
      n_checks++;
      if (starve !== (k >= LIMIT) || req !== 1'b1) $display("FAIL starve_wait%0d: starve=%0d req=%0d", k, starve, req);
      else n_pass++;
    end
    step(0, 0, 1);
    n_checks++;
    if (starve !== 1'b0 || done !== 1'b1) $display("FAIL starve_grant: starve=%0d done=%0d want 0 1", starve, done);
    else n_pass++;
    $display("starve: cleared by grant, done=%0d", done);
  endtask

  task automatic test_sparse();
    int granted = 0;
    int c = 0;
    apply_reset();
    step(1, 4, 0);
    step(0, 0, 0);
    while (granted < 4 && c < 40) begin
      n_checks++;
      if (req !== 1'b1) $display("FAIL sparse_req%0d: req=%0d want 1", c, req);
      else n_pass++;
      step(0, 0, c[0]);
      if (c[0]) granted++;
      n_checks++;
      if (done !== (granted == 4)) $display("FAIL sparse_done%0d: done=%0d want %0d", c, done, granted == 4);
      else n_pass++;
      c++;
    end
    n_checks++;
    if (granted !== 4) $display("FAIL sparse_timeout: granted=%0d want 4", granted);
    else n_pass++;
    $display("sparse: done after %0d granted beats in %0d cycles", granted, c);
  endtask

  task automatic test_reset_mid_job();
    apply_reset();
    step(1, 4, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);                       // two beats consumed
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (req !== 1'b0 || count !== 3'd0 || busy !== 1'b0) $display("FAIL midreset_async: req=%0d count=%0d busy=%0d want 0 0 0", req, count, busy);
    else n_pass++;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 1);
      n_checks++;
      if (done !== 1'b0 || dut_vec() !== model_vec()) $display("FAIL midreset_after%0d: got %b want %b", c, dut_vec(), model_vec());
      else n_pass++;
    end
    $display("reset_mid_job: no done after release");
  endtask

  task automatic test_random();
    int errs = 0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom_range(0, 9) < 6);
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        $display("FAIL random%0d: got %b want %b", c, dut_vec(), model_vec());
        errs++;
      end else n_pass++;
    end
    $display("random: 400 cycles, %0d differences", errs);
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_full();
    test_starve();
    test_sparse();
    test_reset_mid_job();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
